mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data bus width.
REQ-002 Parameter ADDR_WIDTH, default 32, address bus width.
REQ-003 Parameter TIMEOUT, default 16, max WAIT cycles before abort (>=2).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 if_req  input  1  fetch request; held with if_addr until if_ready.
REQ-007 if_addr  input  ADDR_WIDTH  fetch address.
REQ-008 if_rdata  output  DATA_WIDTH  fetched instruction, valid when if_ready=1.
REQ-009 if_ready  output  1  one-cycle fetch completion pulse.
REQ-010 d_req  input  1  load/store request; held with d_* inputs until d_ready.
REQ-011 d_we  input  1  1=store, 0=load.
REQ-012 d_addr  input  ADDR_WIDTH  data address.
REQ-013 d_wdata  input  DATA_WIDTH  store data.
REQ-014 d_be  input  4  store byte enables.
REQ-015 d_rdata  output  DATA_WIDTH  load data, valid when d_ready=1.
REQ-016 d_ready  output  1  one-cycle data completion pulse.
REQ-017 mem_req  output  1  one-cycle memory command strobe.
REQ-018 mem_we, mem_addr, mem_wdata, mem_be  output  1/ADDR_WIDTH/DATA_WIDTH/4  registered command fields, stable from mem_req until mem_rvalid.
REQ-019 mem_rdata  input  DATA_WIDTH  memory read data, valid with mem_rvalid.
REQ-020 mem_rvalid  input  1  memory completion (read data or write ack); never in the mem_req cycle.
REQ-021 busy  output  1  high in any state except IDLE.
REQ-022 err  output  1  sticky timeout flag.

Function
REQ-023 FSM states: IDLE, ISSUE, WAIT, RESP; all outputs registered.
REQ-024 IDLE: request present -> latch winner's command fields and winner id, go to ISSUE; none -> stay.
REQ-025 Arbitration: single requester wins; both requesting -> winner is the port not granted last (round-robin); last_grant updates on every grant.
REQ-026 ISSUE: mem_req=1 for exactly this cycle; next state WAIT; wait counter cleared.
REQ-027 WAIT: mem_rvalid=1 -> capture mem_rdata (zero for stores) into winner's rdata, go to RESP; else counter increments.
REQ-028 WAIT with counter reaching TIMEOUT-1 and no mem_rvalid -> err set, winner's rdata=0, go to RESP.
REQ-029 RESP: winner's ready=1 for exactly this cycle, then IDLE; loser's ready stays 0.
REQ-030 In RESP both req inputs are ignored, so a held req is not re-issued; a new grant can occur in the following IDLE cycle.
REQ-031 mem_rvalid outside WAIT is ignored with no state change.
REQ-032 Minimum latency: req high at edge N -> mem_req in cycle N+1, ready in cycle N+3 for a 1-cycle memory; throughput one transaction per 4 cycles.
REQ-033 rdata outputs hold their value until the next completion on the same port.
REQ-034 Fetch transactions always drive mem_we=0 and mem_be=4'b1111.
REQ-035 err cleared only by rst.

Reset
REQ-036 rst=1 at an edge -> state IDLE; mem_req, if_ready, d_ready, busy, err = 0; if_rdata, d_rdata, mem_* command registers = 0; last_grant=fetch (first tie goes to data).
REQ-037 rst in ISSUE/WAIT/RESP aborts the transaction with no ready pulse; a late mem_rvalid after reset is ignored by REQ-031.

Verification
REQ-038 Fetch only: if_req=1, if_addr=0x100, memory returns 0x00500093 one cycle after mem_req -> mem_addr=0x100, mem_we=0, if_ready pulse 3 cycles after req, if_rdata=0x00500093.
REQ-039 Store: d_req=1, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_be=4'b0011 -> one mem_req with matching fields, d_ready single pulse, d_rdata=0.
REQ-040 Tie after reset: if_req and d_req high together -> data served first, fetch next; a repeated tie alternates grants.
REQ-041 Held req: if_req held high across RESP -> exactly one mem_req per transaction, no duplicate.
REQ-042 Timeout: TIMEOUT=16, memory never responds -> after 16 WAIT cycles err=1, ready pulse, rdata=0; err persists until rst.
REQ-043 Reset in WAIT: rst pulsed in WAIT, mem_rvalid arrives 2 cycles later -> no ready pulse, busy=0, all outputs at reset values.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch port, the data port, the memory and the arbiter.
// slave is the arbiter's view; master is the requester/memory environment.
interface mem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic                  if_ready;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [3:0]            d_be;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  d_ready;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [3:0]            mem_be;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_rvalid;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
               mem_rdata, mem_rvalid,
        output if_rdata, if_ready, d_rdata, d_ready,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
               mem_rdata, mem_rvalid,
        input  if_rdata, if_ready, d_rdata, d_ready,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single-outstanding memory port.
// Round-robin on ties, one transaction per IDLE->ISSUE->WAIT->RESP pass,
// WAIT timeout sets a sticky error and completes the winner with zero data.
module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus,
    output logic          busy,
    output logic          err
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam int            CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic          GNT_IF   = 1'b0;
    localparam logic          GNT_D    = 1'b1;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  win_q, win_d;
    logic                  last_q, last_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]            mem_be_q, mem_be_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  if_ready_q, if_ready_d;
    logic                  d_ready_q, d_ready_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;
    logic                  gnt;
    logic                  done;
    logic [DATA_WIDTH-1:0] rd;

    // Next-state and next-output logic; every output is the registered copy of its _d.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        win_d       = win_q;
        last_d      = last_q;
        mem_req_d   = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;
        err_d       = err_q;
        gnt         = GNT_IF;
        done        = 1'b0;
        rd          = '0;

        unique case (state_q)
            IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    // Data wins if alone, or on a tie when fetch was granted last.
                    gnt       = bus.d_req && (!bus.if_req || last_q == GNT_IF);
                    win_d     = gnt;
                    last_d    = gnt;
                    mem_req_d = 1'b1;
                    state_d   = ISSUE;
                    if (gnt == GNT_D) begin
                        mem_we_d    = bus.d_we;
                        mem_addr_d  = bus.d_addr;
                        mem_wdata_d = bus.d_wdata;
                        mem_be_d    = bus.d_be;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = bus.if_addr;
                        mem_wdata_d = '0;
                        mem_be_d    = 4'b1111;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                if (bus.mem_rvalid) begin
                    done = 1'b1;
                    rd   = mem_we_q ? '0 : bus.mem_rdata;
                end else if (cnt_q == CNT_LAST) begin
                    done  = 1'b1;
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
                // Ready and rdata are loaded on entry to RESP so they are visible during RESP.
                if (done) begin
                    state_d = RESP;
                    if (win_q == GNT_D) begin
                        d_rdata_d = rd;
                        d_ready_d = 1'b1;
                    end else begin
                        if_rdata_d = rd;
                        if_ready_d = 1'b1;
                    end
                end
            end
            RESP: begin
                // Requests are deliberately not sampled here so a held req is not re-issued.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            win_q       <= GNT_IF;
            last_q      <= GNT_IF;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            win_q       <= win_d;
            last_q      <= last_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ready_q  <= if_ready_d;
            d_ready_q   <= d_ready_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_ready   = d_ready_q;
    assign busy          = busy_q;
    assign err           = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table of request patterns, a memory model with
// programmable latency, and scoreboard queues for commands and completions.
module tb_mem_arbiter;
    logic clk;
    logic rst;
    logic busy;
    logic err;

    mem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    mem_arbiter dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy),
        .err  (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        bit          chk_wd;
    } cmd_t;

    typedef struct {
        bit          port;   // 0 fetch, 1 data
        logic [31:0] data;
    } rsp_t;

    typedef struct {
        bit          ir;
        logic [31:0] ia;
        bit          dr;
        bit          dwe;
        logic [31:0] da;
        logic [31:0] dwd;
        logic [3:0]  dbe;
        int          lat;      // memory latency, 0 = never answers
        bit          first_d;  // expected first winner is data
        int          exp_cyc;  // edges from request to first ready
    } vec_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    vec_t vecs[9];

    int          checks = 0;
    int          errors = 0;
    int          nreq   = 0;
    int          mem_lat = 1;
    int          mcnt   = 0;
    bit          pend   = 1'b0;
    logic        pwe    = 1'b0;
    logic [31:0] paddr  = '0;

    function automatic logic [31:0] memdata(logic [31:0] a);
        return (a == 32'h100) ? 32'h0050_0093 : {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // One clock: sample DUT at the falling edge, score, then advance the memory model.
    task automatic tick();
        cmd_t c;
        rsp_t r;
        @(negedge clk);
        if (bus.mem_req) begin
            nreq++;
            if (cmd_q.size() == 0) begin
                chk("mem_req_unexpected", 32'(bus.mem_req), 32'd0);
            end else begin
                c = cmd_q.pop_front();
                chk("mem_we",   32'(bus.mem_we), 32'(c.we));
                chk("mem_addr", bus.mem_addr, c.addr);
                chk("mem_be",   32'(bus.mem_be), 32'(c.be));
                if (c.chk_wd) chk("mem_wdata", bus.mem_wdata, c.wdata);
            end
        end
        if (bus.if_ready || bus.d_ready) begin
            if (rsp_q.size() == 0) begin
                chk("ready_unexpected", 32'({bus.d_ready, bus.if_ready}), 32'd0);
            end else begin
                r = rsp_q.pop_front();
                chk("ready_port", 32'({bus.d_ready, bus.if_ready}), r.port ? 32'd2 : 32'd1);
                chk("rdata", r.port ? bus.d_rdata : bus.if_rdata, r.data);
            end
        end
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'hCAFE_F00D;
        if (pend) begin
            mcnt--;
            if (mcnt == 0) begin
                pend           = 1'b0;
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = pwe ? 32'hFFFF_FFFF : memdata(paddr);
            end
        end
        if (bus.mem_req && mem_lat != 0) begin
            pend  = 1'b1;
            mcnt  = mem_lat;
            pwe   = bus.mem_we;
            paddr = bus.mem_addr;
        end
    endtask

    task automatic reset_chk(string p);
        chk({p, "_mem_req"},   32'(bus.mem_req), 32'd0);
        chk({p, "_if_ready"},  32'(bus.if_ready), 32'd0);
        chk({p, "_d_ready"},   32'(bus.d_ready), 32'd0);
        chk({p, "_busy"},      32'(busy), 32'd0);
        chk({p, "_err"},       32'(err), 32'd0);
        chk({p, "_if_rdata"},  bus.if_rdata, 32'd0);
        chk({p, "_d_rdata"},   bus.d_rdata, 32'd0);
        chk({p, "_mem_we"},    32'(bus.mem_we), 32'd0);
        chk({p, "_mem_addr"},  bus.mem_addr, 32'd0);
        chk({p, "_mem_wdata"}, bus.mem_wdata, 32'd0);
        chk({p, "_mem_be"},    32'(bus.mem_be), 32'd0);
    endtask

    task automatic run_vec(vec_t v, string nm);
        cmd_t ci, cd;
        rsp_t ri, rd;
        bit   di, dd, seen;
        int   cyc;
        ci = '{1'b0, v.ia, 32'h0, 4'b1111, 1'b0};
        cd = '{v.dwe, v.da, v.dwd, v.dbe, v.dwe};
        ri = '{1'b0, (v.lat == 0) ? 32'h0 : memdata(v.ia)};
        rd = '{1'b1, (v.lat == 0 || v.dwe) ? 32'h0 : memdata(v.da)};
        if (v.ir && v.dr) begin
            if (v.first_d) begin
                cmd_q.push_back(cd); rsp_q.push_back(rd);
                cmd_q.push_back(ci); rsp_q.push_back(ri);
            end else begin
                cmd_q.push_back(ci); rsp_q.push_back(ri);
                cmd_q.push_back(cd); rsp_q.push_back(rd);
            end
        end else if (v.ir) begin
            cmd_q.push_back(ci); rsp_q.push_back(ri);
        end else begin
            cmd_q.push_back(cd); rsp_q.push_back(rd);
        end
        nreq        = 0;
        mem_lat     = v.lat;
        bus.if_req  = v.ir;
        bus.if_addr = v.ia;
        bus.d_req   = v.dr;
        bus.d_we    = v.dwe;
        bus.d_addr  = v.da;
        bus.d_wdata = v.dwd;
        bus.d_be    = v.dbe;
        di = 1'b0; dd = 1'b0; seen = 1'b0; cyc = 0;
        // Each req is dropped one cycle after its ready, so it is still high through RESP.
        for (int k = 0; k < 200 && (bus.if_req || bus.d_req); k++) begin
            tick();
            cyc++;
            if (cyc == 1) chk({nm, "_busy_issue"}, 32'(busy), 32'd1);
            if (di) bus.if_req = 1'b0;
            if (dd) bus.d_req  = 1'b0;
            di = bus.if_ready;
            dd = bus.d_ready;
            if (!seen && (di || dd)) begin
                seen = 1'b1;
                chk({nm, "_latency"}, 32'(cyc), 32'(v.exp_cyc));
            end
        end
        if (bus.if_req || bus.d_req) begin
            chk({nm, "_complete"}, 32'({bus.d_req, bus.if_req}), 32'd0);
            bus.if_req = 1'b0;
            bus.d_req  = 1'b0;
        end
        tick();
        chk({nm, "_mem_req_count"}, 32'(nreq), 32'(int'(v.ir) + int'(v.dr)));
        chk({nm, "_busy_idle"}, 32'(busy), 32'd0);
        chk({nm, "_rsp_left"}, 32'(rsp_q.size()), 32'd0);
        cmd_q.delete();
        rsp_q.delete();
    endtask

    initial begin
        // ir ia dr dwe da dwd dbe lat first_d exp_cyc
        vecs[0] = '{1'b1, 32'h104, 1'b1, 1'b0, 32'h3000, 32'h0,         4'b1111, 1, 1'b1, 3};
        vecs[1] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,    32'h0,         4'b0000, 1, 1'b0, 3};
        vecs[2] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h2000, 32'hDEADBEEF,  4'b0011, 1, 1'b1, 3};
        vecs[3] = '{1'b1, 32'h108, 1'b1, 1'b0, 32'h3004, 32'h0,         4'b1111, 2, 1'b0, 4};
        vecs[4] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h3008, 32'h0,         4'b1111, 3, 1'b1, 5};
        vecs[5] = '{1'b1, 32'h10C, 1'b1, 1'b1, 32'h2004, 32'h12345678,  4'b1100, 1, 1'b0, 3};
        vecs[6] = '{1'b1, 32'h110, 1'b0, 1'b0, 32'h0,    32'h0,         4'b0000, 2, 1'b0, 4};
        vecs[7] = '{1'b1, 32'h114, 1'b1, 1'b0, 32'h300C, 32'h0,         4'b1111, 1, 1'b1, 3};
        vecs[8] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h4000, 32'h0,         4'b1111, 0, 1'b1, 18};

        rst            = 1'b1;
        bus.if_req     = 1'b0;
        bus.if_addr    = '0;
        bus.d_req      = 1'b0;
        bus.d_we       = 1'b0;
        bus.d_addr     = '0;
        bus.d_wdata    = '0;
        bus.d_be       = '0;
        bus.mem_rdata  = '0;
        bus.mem_rvalid = 1'b0;
        tick();
        tick();
        reset_chk("reset");
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        chk("err_before_timeout", 32'(err), 32'd0);
        run_vec(vecs[8], "timeout");
        chk("timeout_err_set", 32'(err), 32'd1);
        repeat (5) tick();
        chk("timeout_err_sticky", 32'(err), 32'd1);
        mem_lat = 1;

        // Reset while in WAIT; memory answers two cycles after the reset edge.
        nreq        = 0;
        mem_lat     = 3;
        cmd_q.push_back('{1'b0, 32'h200, 32'h0, 4'b1111, 1'b0});
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h200;
        tick();
        tick();
        chk("rw_busy_wait", 32'(busy), 32'd1);
        rst        = 1'b1;
        bus.if_req = 1'b0;
        tick();
        rst = 1'b0;
        reset_chk("rw");
        repeat (5) tick();
        reset_chk("rw_late");
        chk("rw_mem_req_count", 32'(nreq), 32'd1);
        mem_lat = 1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
